// File: rtl/eth_rx_pkt_fifo.sv
// eth_rx_pkt_fifo: store-and-forward receive FIFO between the RGMII MAC and
// the eth_rx parser. Frames are written speculatively and only become
// visible to the reader once their last byte is accepted without error.
// Errored, oversize, or overflowing frames are rolled back and counted.
// Optional build macro: ETH_RX_FIFO_STATS_EN enables frame_cnt/drop_cnt.
// Without it, both counters read as 0.
module eth_rx_pkt_fifo #(
   parameter int DEPTH_LOG2 = 11,
   parameter int MAX_LEN    = 1522
) (
   input  logic        axi_clk,
   input  logic        axi_rstn,
   input  logic [7:0]  rgmii_rdata,
   input  logic        rgmii_rvalid,
   input  logic        rgmii_rlast,
   input  logic        rgmii_ruser,
   output logic        rgmii_rready,
   output logic [7:0]  m_rdata,
   output logic        m_rvalid,
   output logic        m_rlast,
   input  logic        m_rready,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = $clog2(MAX_LEN + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_STORE   = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   // word = {last, data}
   logic [8:0]    mem [DEPTH];

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] wr_commit_q, wr_commit_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] len_q, len_d;
   logic          rready_q;
   logic [7:0]    mdata_q, mdata_d;
   logic          mlast_q, mlast_d;
   logic          mvalid_q, mvalid_d;

   logic [PW-1:0] used;
   logic          full;
   logic          accept;
   logic          we;
   logic          commit_ev;
   logic          drop_ev;
   logic          readable;
   logic          load;
   logic [8:0]    rd_word;

   // Full is taken from registered pointers only, so a read in the same
   // cycle frees space for the following cycle, not the current one.
   assign used     = wr_ptr_q - rd_ptr_q;
   assign full     = (used == PW'(DEPTH));
   assign accept   = rgmii_rvalid & rready_q;

   // Write FSM: speculative store, commit on good last byte, roll back otherwise
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      len_d       = len_q;
      we          = 1'b0;
      commit_ev   = 1'b0;
      drop_ev     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (full) begin
                  if (rgmii_rlast) drop_ev = 1'b1;
                  else             state_d = S_DISCARD;
               end else if (rgmii_rlast) begin
                  // single-byte frame resolves in this cycle
                  if (rgmii_ruser) begin
                     drop_ev = 1'b1;
                  end else begin
                     we          = 1'b1;
                     wr_ptr_d    = wr_ptr_q + PW'(1);
                     wr_commit_d = wr_ptr_q + PW'(1);
                     commit_ev   = 1'b1;
                  end
               end else begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + PW'(1);
                  len_d    = LW'(1);
                  state_d  = S_STORE;
               end
            end
         end
         S_STORE: begin
            if (accept) begin
               if (rgmii_rlast) begin
                  // len_q >= MAX_LEN here means the frame is MAX_LEN+1 or longer
                  if (rgmii_ruser || full || (len_q >= LW'(MAX_LEN))) begin
                     wr_ptr_d = wr_commit_q;
                     drop_ev  = 1'b1;
                  end else begin
                     we          = 1'b1;
                     wr_ptr_d    = wr_ptr_q + PW'(1);
                     wr_commit_d = wr_ptr_q + PW'(1);
                     commit_ev   = 1'b1;
                  end
                  state_d = S_IDLE;
               end else if (full || (len_q == LW'(MAX_LEN))) begin
                  wr_ptr_d = wr_commit_q;
                  state_d  = S_DISCARD;
               end else begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + PW'(1);
                  len_d    = len_q + LW'(1);
               end
            end
         end
         S_DISCARD: begin
            if (accept && rgmii_rlast) begin
               drop_ev = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Storage array; contents are don't-care after reset since pointers clear
   always_ff @(posedge axi_clk) begin
      if (we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {rgmii_rlast, rgmii_rdata};
   end

   // Reader only sees bytes behind wr_commit, so partial frames stay hidden
   assign readable = (rd_ptr_q != wr_commit_q);
   assign load     = readable & (~mvalid_q | m_rready);
   assign rd_word  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

   // Output register next-state: refill when empty or being drained
   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(load);
      mdata_d  = mdata_q;
      mlast_d  = mlast_q;
      mvalid_d = mvalid_q;
      if (load) begin
         mdata_d  = rd_word[7:0];
         mlast_d  = rd_word[8];
         mvalid_d = 1'b1;
      end else if (m_rready) begin
         mvalid_d = 1'b0;
      end
   end

   // State, pointer and output-stage registers
   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         rready_q    <= 1'b0;
         mdata_q     <= '0;
         mlast_q     <= 1'b0;
         mvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         rready_q    <= 1'b1;
         mdata_q     <= mdata_d;
         mlast_q     <= mlast_d;
         mvalid_q    <= mvalid_d;
      end
   end

   assign rgmii_rready = rready_q;
   assign m_rdata      = mdata_q;
   assign m_rlast      = mlast_q;
   assign m_rvalid     = mvalid_q;

`ifdef ETH_RX_FIFO_STATS_EN
   logic [15:0] frame_cnt_q, drop_cnt_q;

   // Good/dropped frame counters, free-running and wrapping
   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (commit_ev) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (drop_ev)   drop_cnt_q  <= drop_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = commit_ev ^ drop_ev;
   assign frame_cnt    = '0;
   assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// Directed bench for eth_rx_pkt_fifo: a default-size instance plus a
// 64-byte instance for overflow. Counter expectations follow the
// ETH_RX_FIFO_STATS_EN build macro.
module tb_eth_rx_pkt_fifo;

`ifdef ETH_RX_FIFO_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        axi_clk, axi_rstn;
   logic [7:0]  rdata;
   logic        rvalid, rlast, ruser, sel;
   logic        rv0, rv1, rr0, rr1;
   logic        rready0, rready1;
   logic [7:0]  m_rdata0, m_rdata1;
   logic        m_rvalid0, m_rvalid1, m_rlast0, m_rlast1;
   logic [15:0] frame_cnt0, drop_cnt0, frame_cnt1, drop_cnt1;

   int errors = 0;
   int checks = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];

   assign rv0 = rvalid & ~sel;
   assign rv1 = rvalid & sel;

   eth_rx_pkt_fifo u_dut0 (
      .axi_clk(axi_clk), .axi_rstn(axi_rstn),
      .rgmii_rdata(rdata), .rgmii_rvalid(rv0), .rgmii_rlast(rlast), .rgmii_ruser(ruser),
      .rgmii_rready(rready0),
      .m_rdata(m_rdata0), .m_rvalid(m_rvalid0), .m_rlast(m_rlast0), .m_rready(rr0),
      .frame_cnt(frame_cnt0), .drop_cnt(drop_cnt0));

   eth_rx_pkt_fifo #(.DEPTH_LOG2(6)) u_dut1 (
      .axi_clk(axi_clk), .axi_rstn(axi_rstn),
      .rgmii_rdata(rdata), .rgmii_rvalid(rv1), .rgmii_rlast(rlast), .rgmii_ruser(ruser),
      .rgmii_rready(rready1),
      .m_rdata(m_rdata1), .m_rvalid(m_rvalid1), .m_rlast(m_rlast1), .m_rready(rr1),
      .frame_cnt(frame_cnt1), .drop_cnt(drop_cnt1));

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   // capture handshakes half a cycle ahead of the edge that completes them
   always @(negedge axi_clk) begin
      if (axi_rstn) begin
         if (m_rvalid0 && rr0) q0.push_back({m_rlast0, m_rdata0});
         if (m_rvalid1 && rr1) q1.push_back({m_rlast1, m_rdata1});
      end
   end

   // all tasks run in the phase just after a rising edge
   task automatic do_reset();
      axi_rstn = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; ruser = 1'b0;
      repeat (2) @(posedge axi_clk);
      #1 axi_rstn = 1'b1;
      @(posedge axi_clk); #1;
      q0.delete(); q1.delete();
   endtask

   task automatic send_frame(input int len, input bit err, input logic [7:0] start);
      for (int i = 0; i < len; i++) begin
         rdata  = start + 8'(i);
         rvalid = 1'b1;
         rlast  = (i == len - 1);
         ruser  = (i == len - 1) && err;
         @(posedge axi_clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; ruser = 1'b0;
   endtask

   task automatic wait_q(input bit which, input int n);
      for (int c = 0; c < 5000 && (which ? q1.size() : q0.size()) < n; c++)
         @(posedge axi_clk);
      repeat (4) @(posedge axi_clk);
      #1;
   endtask

   task automatic test_reset();
      axi_rstn = 1'b0; sel = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
      rdata = '0; rvalid = 1'b0; rlast = 1'b0; ruser = 1'b0;
      repeat (2) @(posedge axi_clk);
      #1;
      checks++;
      if (rready0 !== 1'b0 || rready1 !== 1'b0) begin
         errors++; $display("FAIL reset_rready got %b/%b want 0", rready0, rready1);
      end
      checks++;
      if ({m_rvalid0, m_rlast0, m_rdata0} !== 10'd0) begin
         errors++; $display("FAIL reset_out got v=%b l=%b d=%h want 0", m_rvalid0, m_rlast0, m_rdata0);
      end
      checks++;
      if (frame_cnt0 !== 16'd0 || drop_cnt0 !== 16'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", frame_cnt0, drop_cnt0);
      end
      axi_rstn = 1'b1;
      @(posedge axi_clk); #1;
      checks++;
      if (rready0 !== 1'b1) begin
         errors++; $display("FAIL rready_rise got %b want 1", rready0);
      end
   endtask

   task automatic test_good_64();
      int bad;
      do_reset(); sel = 1'b0; rr0 = 1'b1;
      send_frame(64, 1'b0, 8'h00);
      // just past the commit edge: nothing out yet
      checks++;
      if (m_rvalid0 !== 1'b0) begin
         errors++; $display("FAIL lat_early got m_rvalid=%b want 0", m_rvalid0);
      end
      @(posedge axi_clk); #1;
      checks++;
      if (m_rvalid0 !== 1'b1 || m_rdata0 !== 8'h00) begin
         errors++; $display("FAIL lat_first got v=%b d=%h want v=1 d=00", m_rvalid0, m_rdata0);
      end
      wait_q(1'b0, 64);
      checks++;
      if (q0.size() !== 64) begin
         errors++; $display("FAIL good64_size got %0d want 64", q0.size());
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 64; i++)
         if (q0[i] !== {(i == 63), 8'(i)}) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL good64_data got %0d bad bytes want 0", bad);
      end
      checks++;
      if (frame_cnt0 !== 16'(STATS) || drop_cnt0 !== 16'd0) begin
         errors++; $display("FAIL good64_cnt got %0d/%0d want %0d/0", frame_cnt0, drop_cnt0, STATS);
      end
   endtask

   task automatic test_bad_then_good();
      int bad;
      do_reset(); sel = 1'b0; rr0 = 1'b1;
      send_frame(100, 1'b1, 8'h00);
      send_frame(60, 1'b0, 8'h20);
      wait_q(1'b0, 60);
      checks++;
      if (q0.size() !== 60) begin
         errors++; $display("FAIL err_size got %0d want 60", q0.size());
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 60; i++)
         if (q0[i] !== {(i == 59), 8'(8'h20 + i)}) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL err_data got %0d bad bytes want 0", bad);
      end
      checks++;
      if (frame_cnt0 !== 16'(STATS) || drop_cnt0 !== 16'(STATS)) begin
         errors++; $display("FAIL err_cnt got %0d/%0d want %0d/%0d", frame_cnt0, drop_cnt0, STATS, STATS);
      end
   endtask

   task automatic test_overflow();
      int bad;
      do_reset(); sel = 1'b1; rr1 = 1'b0;
      send_frame(40, 1'b0, 8'h00);
      send_frame(40, 1'b0, 8'h80);
      checks++;
      if (rready1 !== 1'b1) begin
         errors++; $display("FAIL ovf_rready got %b want 1", rready1);
      end
      checks++;
      if (m_rvalid1 !== 1'b1 || m_rdata1 !== 8'h00) begin
         errors++; $display("FAIL ovf_hold got v=%b d=%h want v=1 d=00", m_rvalid1, m_rdata1);
      end
      checks++;
      if (frame_cnt1 !== 16'(STATS) || drop_cnt1 !== 16'(STATS)) begin
         errors++; $display("FAIL ovf_cnt got %0d/%0d want %0d/%0d", frame_cnt1, drop_cnt1, STATS, STATS);
      end
      rr1 = 1'b1;
      wait_q(1'b1, 40);
      checks++;
      if (q1.size() !== 40) begin
         errors++; $display("FAIL ovf_size got %0d want 40", q1.size());
      end
      bad = 0;
      for (int i = 0; i < q1.size() && i < 40; i++)
         if (q1[i] !== {(i == 39), 8'(i)}) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL ovf_data got %0d bad bytes want 0", bad);
      end
      sel = 1'b0;
   endtask

   task automatic test_max_len();
      int bad;
      do_reset(); sel = 1'b0; rr0 = 1'b1;
      send_frame(1522, 1'b0, 8'h00);
      wait_q(1'b0, 1522);
      checks++;
      if (q0.size() !== 1522) begin
         errors++; $display("FAIL max_ok_size got %0d want 1522", q0.size());
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 1522; i++)
         if (q0[i] !== {(i == 1521), 8'(i)}) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL max_ok_data got %0d bad bytes want 0", bad);
      end
      q0.delete();
      send_frame(1600, 1'b0, 8'h00);
      send_frame(1, 1'b0, 8'hA5);
      wait_q(1'b0, 1);
      checks++;
      if (q0.size() !== 1 || q0[0] !== 9'h1A5) begin
         errors++; $display("FAIL oversize got n=%0d first=%h want n=1 first=1a5", q0.size(), q0[0]);
      end
      checks++;
      if (frame_cnt0 !== 16'(2 * STATS) || drop_cnt0 !== 16'(STATS)) begin
         errors++; $display("FAIL max_cnt got %0d/%0d want %0d/%0d", frame_cnt0, drop_cnt0, 2 * STATS, STATS);
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      do_reset(); sel = 1'b0; rr0 = 1'b0;
      send_frame(20, 1'b0, 8'h10);
      for (int i = 0; i < 30; i++) begin
         rdata = 8'(8'h60 + i); rvalid = 1'b1; rlast = 1'b0; ruser = 1'b0;
         @(posedge axi_clk); #1;
      end
      axi_rstn = 1'b0; rvalid = 1'b0;
      #1;
      checks++;
      if (m_rvalid0 !== 1'b0 || rready0 !== 1'b0) begin
         errors++; $display("FAIL midrst_out got v=%b rdy=%b want 0/0", m_rvalid0, rready0);
      end
      checks++;
      if (frame_cnt0 !== 16'd0 || drop_cnt0 !== 16'd0) begin
         errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", frame_cnt0, drop_cnt0);
      end
      @(posedge axi_clk); #1;
      axi_rstn = 1'b1;
      @(posedge axi_clk); #1;
      q0.delete(); rr0 = 1'b1;
      send_frame(64, 1'b0, 8'h40);
      wait_q(1'b0, 64);
      checks++;
      if (q0.size() !== 64) begin
         errors++; $display("FAIL midrst_size got %0d want 64", q0.size());
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 64; i++)
         if (q0[i] !== {(i == 63), 8'(8'h40 + i)}) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL midrst_data got %0d bad bytes want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int bad, unstable;
      logic [8:0] exp[$];
      logic [9:0] snap;
      logic       held;
      do_reset(); sel = 1'b0; rr0 = 1'b1;
      send_frame(5, 1'b0, 8'hC0);
      send_frame(1, 1'b0, 8'hD0);
      send_frame(3, 1'b0, 8'hE0);
      for (int i = 0; i < 5; i++) exp.push_back({(i == 4), 8'(8'hC0 + i)});
      exp.push_back(9'h1D0);
      for (int i = 0; i < 3; i++) exp.push_back({(i == 2), 8'(8'hE0 + i)});
      wait_q(1'b0, 9);
      checks++;
      if (q0.size() !== 9) begin
         errors++; $display("FAIL b2b_size got %0d want 9", q0.size());
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 9; i++)
         if (q0[i] !== exp[i]) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL b2b_data got %0d bad bytes want 0", bad);
      end
      checks++;
      if (frame_cnt0 !== 16'(3 * STATS) || drop_cnt0 !== 16'd0) begin
         errors++; $display("FAIL b2b_cnt got %0d/%0d want %0d/0", frame_cnt0, drop_cnt0, 3 * STATS);
      end
      // backpressure: ready one cycle in three, output must hold while stalled
      rr0 = 1'b0;
      send_frame(10, 1'b0, 8'h30);
      repeat (3) @(posedge axi_clk);
      #1;
      q0.delete();
      unstable = 0;
      for (int c = 0; c < 60; c++) begin
         rr0  = (c % 3 == 2);
         snap = {m_rvalid0, m_rlast0, m_rdata0};
         held = m_rvalid0 && !rr0;
         @(posedge axi_clk); #1;
         if (held && {m_rvalid0, m_rlast0, m_rdata0} !== snap) unstable++;
      end
      checks++;
      if (unstable !== 0) begin
         errors++; $display("FAIL bp_hold got %0d changes while stalled want 0", unstable);
      end
      bad = 0;
      for (int i = 0; i < q0.size() && i < 10; i++)
         if (q0[i] !== {(i == 9), 8'(8'h30 + i)}) bad++;
      checks++;
      if (q0.size() !== 10 || bad !== 0) begin
         errors++; $display("FAIL bp_data got n=%0d bad=%0d want n=10 bad=0", q0.size(), bad);
      end
   endtask

   initial begin
      test_reset();
      test_good_64();
      test_bad_then_good();
      test_overflow();
      test_max_len();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_pkt_fifo.md
ETH_RX_PKT_FIFO -- requirements
Module: eth_rx_pkt_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 11, byte-storage depth = 2**DEPTH_LOG2 (2048).
REQ-002 SHALL have parameter MAX_LEN, default 1522, longest frame in bytes accepted; longer frames discarded.
REQ-003 axi_clk  in  1  sole clock; all logic rising-edge.
REQ-004 axi_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 rgmii_rdata  in  8  received byte from RGMII MAC.
REQ-006 rgmii_rvalid  in  1  byte valid.
REQ-007 rgmii_rlast  in  1  last byte of frame.
REQ-008 rgmii_ruser  in  1  frame error flag, sampled with rgmii_rlast.
REQ-009 rgmii_rready  out  1  byte accepted; held 1 whenever out of reset.
REQ-010 m_rdata  out  8  byte to eth_rx parser.
REQ-011 m_rvalid  out  1  output byte valid.
REQ-012 m_rlast  out  1  last byte of committed frame.
REQ-013 m_rready  in  1  eth_rx accepts byte.
REQ-014 frame_cnt  out  16  good frames committed (wraps).
REQ-015 drop_cnt  out  16  frames discarded (wraps).

Function
REQ-016 Storage SHALL be 9-bit words {last, data}; pointers wr_ptr, wr_commit, rd_ptr each DEPTH_LOG2+1 bits, full when wr_ptr - rd_ptr == 2**DEPTH_LOG2.
REQ-017 Write FSM SHALL have states IDLE, STORE, DISCARD; IDLE->STORE on first accepted byte with space, IDLE->DISCARD on first byte when full.
REQ-018 In STORE each accepted byte SHALL be written and wr_ptr incremented; byte count tracked per frame.
REQ-019 STORE->DISCARD SHALL occur on an accepted non-last byte when FIFO full or byte count reaches MAX_LEN; wr_ptr SHALL roll back to wr_commit.
REQ-020 On accepted rlast in STORE with ruser=0 and space available: byte written with last=1, wr_commit <= wr_ptr+1, frame_cnt +1, ->IDLE.
REQ-021 On accepted rlast in STORE with ruser=1 or FIFO full: wr_ptr <= wr_commit, drop_cnt +1, ->IDLE.
REQ-022 In DISCARD bytes SHALL be accepted and ignored; on rlast drop_cnt +1, ->IDLE.
REQ-023 A one-byte frame (rvalid+rlast in IDLE) SHALL be committed or dropped per REQ-020/021 in that cycle.
REQ-024 Reader SHALL see only committed bytes: readable when rd_ptr != wr_commit; uncommitted bytes never appear on m_*.
REQ-025 Output SHALL be a registered stage: first byte of a frame valid 2 cycles after the commit cycle when output stage empty.
REQ-026 m_rdata/m_rlast SHALL hold stable while m_rvalid=1 and m_rready=0; throughput 1 byte/cycle when m_rready=1.
REQ-027 Simultaneous commit and read, and simultaneous write and read at full, SHALL both proceed; full evaluated from registered pointers.
REQ-028 Counters SHALL wrap 0xFFFF->0x0000.

Reset
REQ-029 On axi_rstn=0: all pointers 0, FSM IDLE, rgmii_rready=0, m_rvalid=0, m_rdata=0, m_rlast=0, frame_cnt=0, drop_cnt=0.
REQ-030 Reset mid-frame SHALL discard all stored and partial data; first frame after release starts clean in IDLE.
REQ-031 rgmii_rready SHALL rise the first cycle after axi_rstn deasserts.

Configuration
REQ-032 Macro ETH_RX_FIFO_STATS_EN defined: frame_cnt/drop_cnt implemented per REQ-020..022, REQ-028.
REQ-033 Macro ETH_RX_FIFO_STATS_EN undefined: counters not implemented, frame_cnt and drop_cnt tied 0; data path unchanged.

Verification
REQ-034 64-byte good frame, m_rready=1 -> 64 bytes out in order, m_rlast on byte 64, first byte 2 cycles after commit, frame_cnt=1.
REQ-035 100-byte frame with ruser=1 at rlast, then 60-byte good frame -> only 60-byte frame output, drop_cnt=1, frame_cnt=1.
REQ-036 DEPTH_LOG2=6, m_rready=0, 40-byte then 40-byte good frames -> first output intact, second dropped, drop_cnt=1, rgmii_rready stays 1.
REQ-037 1600-byte frame with MAX_LEN=1522 -> no output, drop_cnt=1; following 1-byte frame output with m_rlast=1.
REQ-038 axi_rstn pulsed low at byte 30 of a committed-pending frame -> m_rvalid=0, counters 0, next 64-byte frame output correctly.
REQ-039 Build without ETH_RX_FIFO_STATS_EN, repeat REQ-035 -> identical data output, frame_cnt=drop_cnt=0.
